// File: rtl/tdc_pkg.sv
// Shared widths, input word layout and clamp helper for the TDC interval readout path.
// TDC_TIMESTAMP_EN widens each stored entry with a 14-bit cycle timestamp.
package tdc_pkg;

  localparam int unsigned COUNTER_DIG  = 10;
  localparam int unsigned NUM_DECODE   = 7;
  localparam int unsigned TAPS_PER_CLK = 120;
  localparam int unsigned OUT_W        = 18;
  localparam int unsigned TS_W         = 14;
  localparam int unsigned TDC_W        = COUNTER_DIG + 2 * NUM_DECODE;

`ifdef TDC_TIMESTAMP_EN
  localparam int unsigned DATA_W = OUT_W + TS_W;
`else
  localparam int unsigned DATA_W = OUT_W;
`endif

  typedef struct packed {
    logic [COUNTER_DIG-1:0] coarse;
    logic [NUM_DECODE-1:0]  start;
    logic [NUM_DECODE-1:0]  stop;
  } tdc_word_t;

  // Negative values floor at zero, oversized values saturate at all-ones.
  function automatic logic [OUT_W-1:0] clampOut(input logic signed [OUT_W+1:0] val);
    logic [OUT_W-1:0] res;
    if (val[OUT_W+1]) begin
      res = '0;
    end else if (val[OUT_W]) begin
      res = '1;
    end else begin
      res = val[OUT_W-1:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/tdc_interval_fifo_if.sv
// Capture-side input strobe plus readout-side valid/ready stream of tdc_interval_fifo.
// oData width follows tdc_pkg::DATA_W, which TDC_TIMESTAMP_EN widens.
interface tdc_interval_fifo_if #(
  parameter int unsigned DEPTH = 16
);
  logic [tdc_pkg::TDC_W-1:0]  iTDC;
  logic                       iValid;
  logic [tdc_pkg::DATA_W-1:0] oData;
  logic                       oValid;
  logic                       iReady;
  logic [$clog2(DEPTH):0]     oCount;
  logic                       oOverflow;
  logic                       oNegative;

  modport master (
    output iTDC, iValid, iReady,
    input  oData, oValid, oCount, oOverflow, oNegative
  );

  modport slave (
    input  iTDC, iValid, iReady,
    output oData, oValid, oCount, oOverflow, oNegative
  );
endinterface

// File: rtl/tdc_sync_fifo.sv
// First-word fall-through synchronous FIFO with occupancy count; head is always on oRdData.
// A write while full is accepted only if a pop happens on the same edge.
module tdc_sync_fifo #(
  parameter int unsigned WIDTH = 18,
  parameter int unsigned DEPTH = 16
) (
  input  logic                   iClk,
  input  logic                   iRst,
  input  logic                   iWrEn,
  input  logic [WIDTH-1:0]       iWrData,
  input  logic                   iRdEn,
  output logic [WIDTH-1:0]       oRdData,
  output logic [$clog2(DEPTH):0] oCount,
  output logic                   oFull,
  output logic                   oEmpty
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wrPtr, rdPtr;
  logic [CNT_W-1:0] count;
  logic             doPush, doPop;

  assign oFull  = (count == CNT_W'(DEPTH));
  assign oEmpty = (count == '0);
  assign doPop  = iRdEn && !oEmpty;
  assign doPush = iWrEn && (!oFull || doPop);

  always_ff @(posedge iClk) begin
    if (iRst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
      // Cleared so the head reads zero out of reset, even after a mid-stream reset.
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (doPush) begin
        mem[wrPtr] <= iWrData;
        wrPtr      <= wrPtr + 1'b1;
      end
      if (doPop) begin
        rdPtr <= rdPtr + 1'b1;
      end
      if (doPush && !doPop) begin
        count <= count + 1'b1;
      end else if (doPop && !doPush) begin
        count <= count - 1'b1;
      end
    end
  end

  assign oRdData = mem[rdPtr];
  assign oCount  = count;
endmodule

// File: rtl/tdc_interval_fifo.sv
// Converts TDC result words to tap intervals in a two-stage pipeline and queues them for readout.
// Define TDC_TIMESTAMP_EN to prepend a 14-bit capture timestamp to every entry.
module tdc_interval_fifo
  import tdc_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input logic               iClk,
  input logic               iRst,
  tdc_interval_fifo_if.slave bus
);
  localparam logic [OUT_W+1:0] TapsK = (OUT_W + 2)'(TAPS_PER_CLK);

  tdc_word_t word;
  assign word = tdc_word_t'(bus.iTDC);

  logic                    s1Valid;
  logic [OUT_W+1:0]        s1Product;
  logic [NUM_DECODE-1:0]   s1Start, s1Stop;
  logic                    s2Valid, s2Neg;
  logic [OUT_W-1:0]        s2Interval;
  logic signed [OUT_W+1:0] diff;
  logic                    overflowFlag, negativeFlag;
  logic [DATA_W-1:0]       fifoWrData, fifoRdData;
  logic                    fifoFull, fifoEmpty;
  logic [$clog2(DEPTH):0]  fifoCount;

  assign diff = $signed(s1Product) + $signed((OUT_W + 2)'(s1Start))
              - $signed((OUT_W + 2)'(s1Stop));

  always_ff @(posedge iClk) begin
    if (iRst) begin
      s1Valid    <= 1'b0;
      s1Product  <= '0;
      s1Start    <= '0;
      s1Stop     <= '0;
      s2Valid    <= 1'b0;
      s2Neg      <= 1'b0;
      s2Interval <= '0;
    end else begin
      s1Valid    <= bus.iValid;
      s1Product  <= (OUT_W + 2)'(word.coarse) * TapsK;
      s1Start    <= word.start;
      s1Stop     <= word.stop;
      s2Valid    <= s1Valid;
      s2Neg      <= diff[OUT_W+1];
      s2Interval <= clampOut(diff);
    end
  end

  // Full implies a head entry exists, so iReady alone decides whether a slot frees up.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      overflowFlag <= 1'b0;
      negativeFlag <= 1'b0;
    end else begin
      if (s2Valid && fifoFull && !bus.iReady) begin
        overflowFlag <= 1'b1;
      end
      if (s2Valid && s2Neg) begin
        negativeFlag <= 1'b1;
      end
    end
  end

`ifdef TDC_TIMESTAMP_EN
  logic [TS_W-1:0] tsCnt, s1Ts, s2Ts;

  always_ff @(posedge iClk) begin
    if (iRst) begin
      tsCnt <= '0;
      s1Ts  <= '0;
      s2Ts  <= '0;
    end else begin
      tsCnt <= tsCnt + 1'b1;
      s1Ts  <= tsCnt;
      s2Ts  <= s1Ts;
    end
  end

  assign fifoWrData = {s2Ts, s2Interval};
`else
  assign fifoWrData = s2Interval;
`endif

  tdc_sync_fifo #(
    .WIDTH(DATA_W),
    .DEPTH(DEPTH)
  ) uFifo (
    .iClk   (iClk),
    .iRst   (iRst),
    .iWrEn  (s2Valid),
    .iWrData(fifoWrData),
    .iRdEn  (bus.iReady),
    .oRdData(fifoRdData),
    .oCount (fifoCount),
    .oFull  (fifoFull),
    .oEmpty (fifoEmpty)
  );

  assign bus.oData     = fifoRdData;
  assign bus.oValid    = !fifoEmpty;
  assign bus.oCount    = fifoCount;
  assign bus.oOverflow = overflowFlag;
  assign bus.oNegative = negativeFlag;
endmodule

// File: tb/tb_tdc_interval_fifo.sv
// Directed plus randomized bench for tdc_interval_fifo against a queue-based reference model.
// Timestamp checks are active when TDC_TIMESTAMP_EN is defined.
module tb_tdc_interval_fifo;
  import tdc_pkg::*;

  localparam int unsigned DEPTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tdc_interval_fifo_if #(.DEPTH(DEPTH)) bus ();

  tdc_interval_fifo #(.DEPTH(DEPTH)) dut (
    .iClk(clk),
    .iRst(rst),
    .bus (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: entries are computed when the hit arrives, then delayed two edges.
  logic [DATA_W-1:0] mq [$];
  logic [DATA_W-1:0] d1 = '0, d2 = '0;
  bit d1v = 0, d2v = 0, d1n = 0, d2n = 0;
  bit mOvf = 0, mNeg = 0;
  int tsM = 0;

  function automatic logic [TDC_W-1:0] mkWord(input int c, input int s, input int p);
    logic [TDC_W-1:0] w;
    w = {COUNTER_DIG'(c), NUM_DECODE'(s), NUM_DECODE'(p)};
    return w;
  endfunction

  function automatic int rawVal(input logic [TDC_W-1:0] w);
    int c, s, p;
    c = int'(w[TDC_W-1 -: COUNTER_DIG]);
    s = int'(w[2*NUM_DECODE-1 -: NUM_DECODE]);
    p = int'(w[NUM_DECODE-1:0]);
    return c * int'(TAPS_PER_CLK) + s - p;
  endfunction

  function automatic logic [DATA_W-1:0] expEntry(input logic [TDC_W-1:0] w, input int ts);
    int v;
    longint r;
    v = rawVal(w);
    if (v < 0) v = 0;
    if (v > (1 << OUT_W) - 1) v = (1 << OUT_W) - 1;
    r = longint'(v);
`ifdef TDC_TIMESTAMP_EN
    r = r + (longint'(ts) << OUT_W);
`endif
    return DATA_W'(r);
  endfunction

  task automatic modelEdge();
    if (rst) begin
      mq.delete();
      d1v = 0; d2v = 0; mOvf = 0; mNeg = 0; tsM = 0;
    end else begin
      if (mq.size() > 0 && bus.iReady) void'(mq.pop_front());
      if (d2v) begin
        if (mq.size() < DEPTH) mq.push_back(d2);
        else mOvf = 1;
        if (d2n) mNeg = 1;
      end
      d2v = d1v; d2 = d1; d2n = d1n;
      d1v = bus.iValid;
      if (bus.iValid) begin
        d1  = expEntry(bus.iTDC, tsM);
        d1n = rawVal(bus.iTDC) < 0;
      end
      tsM = (tsM + 1) % (1 << TS_W);
    end
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkAll();
    check("count", 64'(bus.oCount), 64'(mq.size()));
    check("valid", 64'(bus.oValid), 64'(mq.size() > 0));
    if (mq.size() > 0) check("data", 64'(bus.oData), 64'(mq[0]));
    check("overflow", 64'(bus.oOverflow), 64'(mOvf));
    check("negative", 64'(bus.oNegative), 64'(mNeg));
  endtask

  // Drives one cycle from a negedge, updates the model at the posedge, checks at the next negedge.
  task automatic cyc(input bit r, input bit v, input logic [TDC_W-1:0] w, input bit rdy);
    rst = r; bus.iValid = v; bus.iTDC = w; bus.iReady = rdy;
    @(posedge clk);
    modelEdge();
    @(negedge clk);
    checkAll();
  endtask

  function automatic logic [TDC_W-1:0] rndWord();
    int c;
    c = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 1023));
    return mkWord(c, int'($urandom_range(0, 127)), int'($urandom_range(0, 127)));
  endfunction

  initial begin
    logic [TS_W-1:0] t1, t2;
    t1 = '0; t2 = '0;
    bus.iValid = 1'b0; bus.iTDC = '0; bus.iReady = 1'b0;

    // Reset state
    cyc(1, 1, mkWord(1, 2, 3), 1);
    cyc(1, 0, '0, 0);
    check("rst_data", 64'(bus.oData), 64'd0);
    check("rst_valid", 64'(bus.oValid), 64'd0);

    // Conversion and 3-edge latency
    cyc(0, 1, mkWord(3, 40, 10), 0);
    check("lat_k", 64'(bus.oValid), 64'd0);
    cyc(0, 0, '0, 0);
    check("lat_k1", 64'(bus.oValid), 64'd0);
    cyc(0, 0, '0, 0);
    check("lat_k2", 64'(bus.oValid), 64'd1);
    check("conv390", 64'(bus.oData[OUT_W-1:0]), 64'd390);
    cyc(0, 0, '0, 1);

    // Negative clamp, sticky flag
    cyc(0, 1, mkWord(0, 5, 20), 0);
    cyc(0, 1, mkWord(1, 0, 0), 0);
    cyc(0, 0, '0, 0);
    check("clamp0", 64'(bus.oData[OUT_W-1:0]), 64'd0);
    check("neg_set", 64'(bus.oNegative), 64'd1);
    cyc(0, 0, '0, 0);
    cyc(0, 0, '0, 1);
    check("conv120", 64'(bus.oData[OUT_W-1:0]), 64'd120);
    check("neg_sticky", 64'(bus.oNegative), 64'd1);
    cyc(0, 0, '0, 1);

    // Fill to full, then push and pop on the same edge
    for (int i = 0; i < 16; i++) cyc(0, 1, rndWord(), 0);
    cyc(0, 0, '0, 0);
    cyc(0, 0, '0, 0);
    check("full16", 64'(bus.oCount), 64'd16);
    cyc(0, 1, mkWord(7, 7, 7), 0);
    cyc(0, 0, '0, 0);
    cyc(0, 0, '0, 1);
    check("pushpop_cnt", 64'(bus.oCount), 64'd16);
    check("pushpop_ovf", 64'(bus.oOverflow), 64'd0);
    for (int i = 0; i < 16; i++) cyc(0, 0, '0, 1);
    check("drained", 64'(bus.oCount), 64'd0);

    // Overflow: 17 back-to-back hits with no readout
    for (int i = 0; i < 17; i++) cyc(0, 1, mkWord(i + 1, i, 0), 0);
    cyc(0, 0, '0, 0);
    cyc(0, 0, '0, 0);
    check("ovf_cnt", 64'(bus.oCount), 64'd16);
    check("ovf_flag", 64'(bus.oOverflow), 64'd1);
    for (int i = 0; i < 16; i++) begin
      check("ovf_order", 64'(bus.oData[OUT_W-1:0]), 64'((i + 1) * 120 + i));
      cyc(0, 0, '0, 1);
    end
    check("ovf_17th_absent", 64'(bus.oValid), 64'd0);

    // Reset mid-stream: 3 queued, 2 in flight
    for (int i = 0; i < 3; i++) cyc(0, 1, rndWord(), 0);
    cyc(0, 0, '0, 0);
    cyc(0, 0, '0, 0);
    cyc(0, 1, rndWord(), 0);
    cyc(0, 1, rndWord(), 0);
    cyc(1, 1, rndWord(), 0);
    check("mrst_cnt", 64'(bus.oCount), 64'd0);
    check("mrst_valid", 64'(bus.oValid), 64'd0);
    check("mrst_data", 64'(bus.oData), 64'd0);
    check("mrst_ovf", 64'(bus.oOverflow), 64'd0);
    for (int i = 0; i < 4; i++) cyc(0, 0, '0, 0);
    check("mrst_stale", 64'(bus.oCount), 64'd0);

`ifdef TDC_TIMESTAMP_EN
    // Hits 16 cycles apart carry timestamps 16 apart
    cyc(1, 0, '0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, '0, 0);
    cyc(0, 1, mkWord(2, 0, 0), 0);
    for (int i = 0; i < 15; i++) cyc(0, 0, '0, 0);
    cyc(0, 1, mkWord(4, 0, 0), 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, '0, 0);
    t1 = bus.oData[DATA_W-1:OUT_W];
    cyc(0, 0, '0, 1);
    t2 = bus.oData[DATA_W-1:OUT_W];
    check("ts_diff", 64'(t2 - t1), 64'd16);
    cyc(0, 0, '0, 1);
`endif

    // Random traffic: slow readout first to provoke overflow, then fast
    for (int i = 0; i < 400; i++) begin
      cyc(0, $urandom_range(0, 1) == 1, rndWord(),
          (i < 150) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0));
    end
    for (int i = 0; i < 24; i++) cyc(0, 0, '0, 1);
    check("final_empty", 64'(bus.oValid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
